// File: rtl/bram_1p_arbiter.sv
// rtl/bram_1p_arbiter.sv - two-requester arbiter in front of a single-port byte-enable BRAM.
// BRAM_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module bram_1p_arbiter #(
  parameter int NB_COL        = 2,
  parameter int COL_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    req_i,
  input  logic [RAM_ADDR_BITS-1:0]      addr0_i,
  input  logic [RAM_ADDR_BITS-1:0]      addr1_i,
  input  logic [NB_COL-1:0]             we0_i,
  input  logic [NB_COL-1:0]             we1_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   wdata0_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   wdata1_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    rvalid_o,
  output logic [NB_COL*COL_WIDTH-1:0]   rdata_o,
  output logic                          busy_o,
  output logic                          mem_en_o,
  output logic [NB_COL-1:0]             mem_we_o,
  output logic [RAM_ADDR_BITS-1:0]      mem_addr_o,
  output logic [NB_COL*COL_WIDTH-1:0]   mem_data_o,
  input  logic [NB_COL*COL_WIDTH-1:0]   mem_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                         state_q, state_d;
  logic                           win_q, win_d;
  logic                           last_q, last_d;
  logic [NB_COL-1:0]              we_q, we_d;
  logic [1:0]                     gnt_q, gnt_d;
  logic [1:0]                     rvalid_q, rvalid_d;
  logic                           mem_en_q, mem_en_d;
  logic [NB_COL-1:0]              mem_we_q, mem_we_d;
  logic [RAM_ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [NB_COL*COL_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                           pick;

  always_comb begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
    pick = ~req_i[0];
`else
    // On a tie the requester that was not granted last wins.
    pick = (req_i == 2'b11) ? ~last_q : req_i[1];
`endif
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    mem_en_d   = 1'b0;
    mem_we_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = ISSUE;
          win_d      = pick;
          last_d     = pick;
          we_d       = pick ? we1_i : we0_i;
          mem_addr_d = pick ? addr1_i : addr0_i;
          mem_data_d = pick ? wdata1_i : wdata0_i;
          gnt_d      = pick ? 2'b10 : 2'b01;
          mem_en_d   = 1'b1;
          mem_we_d   = pick ? we1_i : we0_i;
        end
      end
      ISSUE: begin
        // Reads wait one cycle for the BRAM output register.
        if (we_q == '0) begin
          state_d  = RESP;
          rvalid_d = win_q ? 2'b10 : 2'b01;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= '0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = mem_data_i;
  assign busy_o     = (state_q != IDLE);
  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_bram_1p_arbiter.sv
// tb/tb_bram_1p_arbiter.sv - directed bench for bram_1p_arbiter with a byte-enable BRAM model.
module tb_bram_1p_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [2:0]  addr0, addr1;
  logic [1:0]  we0, we1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        busy, mem_en;
  logic [1:0]  mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rd;
  logic        clr_mem;
  logic [15:0] mem [0:7];
  int          n_cmp;
  int          n_fail;

  bram_1p_arbiter #(.NB_COL(2), .COL_WIDTH(8), .RAM_ADDR_BITS(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .addr0_i(addr0), .addr1_i(addr1), .we0_i(we0), .we1_i(we1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
    end else if (mem_en) begin
      for (int c = 0; c < 2; c++)
        if (mem_we[c]) mem[mem_addr][c*8 +: 8] <= mem_wdata[c*8 +: 8];
      mem_rd <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task test_reset;
    rst = 1'b1; clr_mem = 1'b1; req = 2'b00;
    addr0 = 3'd0; addr1 = 3'd0; we0 = 2'b00; we1 = 2'b00; wdata0 = 16'h0; wdata1 = 16'h0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b exp 00", gnt); end
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 00", rvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b exp 0", mem_en); end
    n_cmp++; if (mem_we !== 2'b00) begin n_fail++; $display("FAIL rst_mem_we: got %b exp 00", mem_we); end
    n_cmp++; if (mem_addr !== 3'd0) begin n_fail++; $display("FAIL rst_mem_addr: got %0d exp 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_data: got %h exp 0000", mem_wdata); end
    rst = 1'b0; clr_mem = 1'b0;
  endtask

  task test_write(input logic [1:0] who, input logic [2:0] a, input logic [1:0] w, input logic [15:0] d);
    @(negedge clk);
    req = who;
    if (who == 2'b01) begin addr0 = a; we0 = w; wdata0 = d; end
    else begin addr1 = a; we1 = w; wdata1 = d; end
    @(negedge clk);
    n_cmp++; if (gnt !== who) begin n_fail++; $display("FAIL wr_gnt: got %b exp %b", gnt, who); end
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL wr_mem_en: got %b exp 1", mem_en); end
    n_cmp++; if (mem_we !== w) begin n_fail++; $display("FAIL wr_mem_we: got %b exp %b", mem_we, w); end
    n_cmp++; if (mem_addr !== a) begin n_fail++; $display("FAIL wr_mem_addr: got %0d exp %0d", mem_addr, a); end
    n_cmp++; if (mem_wdata !== d) begin n_fail++; $display("FAIL wr_mem_data: got %h exp %h", mem_wdata, d); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b exp 1", busy); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_busy: got %b exp 0", busy); end
    n_cmp++; if ({gnt, rvalid, mem_en, mem_we} !== 7'b0) begin n_fail++; $display("FAIL wr_idle_outs: got %b exp 0000000", {gnt, rvalid, mem_en, mem_we}); end
  endtask

  task test_read(input logic [2:0] a, input logic [15:0] exp_data);
    @(negedge clk);
    req = 2'b01; addr0 = a; we0 = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b exp 01", gnt); end
    n_cmp++; if ({mem_en, mem_we} !== 3'b100) begin n_fail++; $display("FAIL rd_mem_ctl: got %b exp 100", {mem_en, mem_we}); end
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_early_rvalid: got %b exp 00", rvalid); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b exp 01", rvalid); end
    n_cmp++; if (rdata !== exp_data) begin n_fail++; $display("FAIL rd_data: got %h exp %h", rdata, exp_data); end
    n_cmp++; if ({gnt, mem_en, busy} !== 4'b0001) begin n_fail++; $display("FAIL rd_resp_ctl: got %b exp 0001", {gnt, mem_en, busy}); end
    @(negedge clk);
    n_cmp++; if ({rvalid, busy} !== 3'b000) begin n_fail++; $display("FAIL rd_end: got %b exp 000", {rvalid, busy}); end
  endtask

  task test_round_robin;
    logic [1:0] exp_g;
    logic [1:0] exp_order [0:3];
    bit         found;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`else
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`endif
    test_write(2'b10, 3'd5, 2'b11, 16'h1234);
    @(negedge clk);
    req = 2'b11; addr0 = 3'd3; addr1 = 3'd5; we0 = 2'b00; we1 = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp_g = exp_order[k];
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
        @(negedge clk);
        if (gnt != 2'b00) found = 1'b1;
      end
      n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b exp %b", k, gnt, exp_g); end
      @(negedge clk);
      n_cmp++; if (rvalid !== exp_g) begin n_fail++; $display("FAIL rr_rvalid%0d: got %b exp %b", k, rvalid, exp_g); end
      n_cmp++; if (rdata !== (exp_g == 2'b01 ? 16'hA5FF : 16'h1234)) begin
        n_fail++; $display("FAIL rr_data%0d: got %h exp %h", k, rdata, (exp_g == 2'b01 ? 16'hA5FF : 16'h1234));
      end
    end
    req = 2'b00;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain_busy: got %b exp 0", busy); end
  endtask

  task test_reset_in_resp;
    @(negedge clk);
    req = 2'b01; addr0 = 3'd3; we0 = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rir_gnt: got %b exp 01", gnt); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rir_in_resp: got %b exp 01", rvalid); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({rvalid, busy, mem_en} !== 4'b0000) begin n_fail++; $display("FAIL rir_async: got %b exp 0000", {rvalid, busy, mem_en}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rir_no_rvalid%0d: got %b exp 00", c, rvalid); end
    end
    req = 2'b11; addr0 = 3'd3; addr1 = 3'd5; we0 = 2'b00; we1 = 2'b00;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rir_tie_gnt: got %b exp 01", gnt); end
    req = 2'b00;
    @(negedge clk); @(negedge clk);
  endtask

  task test_dropped_req;
    @(negedge clk);
    req = 2'b01; addr0 = 3'd2; we0 = 2'b11; wdata0 = 16'h1111;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL drop_gnt0: got %b exp 01", gnt); end
    req = 2'b10; addr1 = 3'd6; we1 = 2'b11; wdata1 = 16'hBEEF;
    @(negedge clk);
    req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({gnt, mem_en} !== 3'b000) begin n_fail++; $display("FAIL drop_no_gnt%0d: got %b exp 000", c, {gnt, mem_en}); end
      @(negedge clk);
    end
    test_read(3'd6, 16'h0000);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_write(2'b01, 3'd3, 2'b11, 16'hA55A);
    test_read(3'd3, 16'hA55A);
    test_write(2'b01, 3'd3, 2'b01, 16'h00FF);
    test_read(3'd3, 16'hA5FF);
    test_round_robin();
    test_reset_in_resp();
    test_dropped_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
